// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the 16 clients and the round-robin arbiter.
// The owner's "done" strobe is called owner_release because "release" is a
// reserved word in SystemVerilog (force/release) and cannot be a signal name.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        owner_release;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        grant_new;

  // Client side: drives requests and release, observes the grant.
  modport master (
    output req, owner_release,
    input  grant_valid, grant_idx, grant_onehot, grant_new
  );

  // Arbiter side: observes requests and release, drives the grant.
  modport slave (
    input  req, owner_release,
    output grant_valid, grant_idx, grant_onehot, grant_new
  );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-client round-robin arbiter with ownership hold and optional preemption.
//
// Handshake: a client asserts req[i] and keeps it high while it wants the
// path. One edge after winning, grant_valid=1, grant_idx/grant_onehot name the
// owner and grant_new pulses for exactly that first cycle. The owner keeps the
// grant until it pulses owner_release, drops its req bit, or (HOLD_LIMIT != 0)
// has held for HOLD_LIMIT cycles while another client is waiting. Any hand-off
// re-arbitrates in the same cycle so the next owner follows with no dead cycle.
// owner_release is ignored while no grant is held.
module rr_arbiter16 #(
  parameter int HOLD_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arbiter16_if.slave bus,
  output logic       dbg_state,
  output logic [3:0] dbg_ptr,
  output logic [7:0] dbg_hold_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Preemption compares against the last permitted hold value; a limit of 0
  // disables preemption entirely, so this constant is never used then.
  localparam logic [7:0] HOLD_LAST = (HOLD_LIMIT == 0) ? 8'd0 : 8'(HOLD_LIMIT - 1);
  localparam bit         PREEMPT_EN = (HOLD_LIMIT != 0);

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic        handoff;
  logic [3:0]  arb_ptr;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;
  logic        new_grant;
  logic        other_req;
  logic        valid_nxt;
  logic [3:0]  idx_nxt;
  logic [15:0] onehot_nxt;

  // State register plus every registered output; reset clears all of it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= 4'd0;
      hold_cnt         <= 8'd0;
      bus.grant_valid  <= 1'b0;
      bus.grant_idx    <= 4'd0;
      bus.grant_onehot <= 16'd0;
      bus.grant_new    <= 1'b0;
    end else begin
      state            <= state_nxt;
      ptr              <= ptr_nxt;
      hold_cnt         <= hold_nxt;
      bus.grant_valid  <= valid_nxt;
      bus.grant_idx    <= idx_nxt;
      bus.grant_onehot <= onehot_nxt;
      bus.grant_new    <= new_grant;
    end
  end

  // Round-robin search starting at arb_ptr; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = arb_ptr + 4'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next state: detect hand-off (release, owner drop, or hold-limit preemption)
  // and pick where the search starts; a hand-off puts the old owner last.
  always_comb begin
    state_nxt = state;
    handoff   = 1'b0;
    arb_ptr   = ptr;
    other_req = |(bus.req & ~bus.grant_onehot);
    case (state)
      IDLE: begin
        if (win_found) state_nxt = BUSY;
      end
      BUSY: begin
        handoff = bus.owner_release
                | ~bus.req[bus.grant_idx]
                | (PREEMPT_EN && (hold_cnt >= HOLD_LAST) && other_req);
        if (handoff) begin
          arb_ptr   = bus.grant_idx + 4'd1;
          state_nxt = win_found ? BUSY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values, registered above so nothing combinational reaches a port.
  always_comb begin
    new_grant  = win_found && ((state == IDLE) || handoff);
    valid_nxt  = (state_nxt == BUSY);
    idx_nxt    = 4'd0;
    if (new_grant)              idx_nxt = win_idx;
    else if (state_nxt == BUSY) idx_nxt = bus.grant_idx;
    onehot_nxt = valid_nxt ? (16'd1 << idx_nxt) : 16'd0;
    ptr_nxt    = handoff ? (bus.grant_idx + 4'd1) : ptr;
    hold_nxt   = hold_cnt;
    if (new_grant || (state_nxt == IDLE)) hold_nxt = 8'd0;
    else if (hold_cnt != 8'hFF)           hold_nxt = hold_cnt + 8'd1;
  end

  assign dbg_state    = state;
  assign dbg_ptr      = ptr;
  assign dbg_hold_cnt = hold_cnt;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 built with HOLD_LIMIT=4.
// Observed grant bundle is packed as {grant_valid, grant_idx, grant_onehot, grant_new}.
module tb_rr_arbiter16;
  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [3:0] dbg_ptr;
  logic [7:0] dbg_hold_cnt;
  int         passed;
  int         total;
  logic [21:0] exp;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.HOLD_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .dbg_state    (dbg_state),
    .dbg_ptr      (dbg_ptr),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout reached simulation limit");
    $fatal(1, "timeout");
  end

  function automatic logic [21:0] obs();
    return {bus.grant_valid, bus.grant_idx, bus.grant_onehot, bus.grant_new};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.req           = 16'd0;
    bus.owner_release = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.req           = 16'h0001;
    bus.owner_release = 1'b0;
    tick();
    tick();
    exp = 22'd0;
    total++;
    if (obs() !== exp) $display("FAIL reset_outputs got %h want %h", obs(), exp); else passed++;
    total++;
    if ({dbg_state, dbg_ptr, dbg_hold_cnt} !== 13'd0)
      $display("FAIL reset_state got %h want 0", {dbg_state, dbg_ptr, dbg_hold_cnt});
    else passed++;
    // Deassert mid-cycle: no grant may appear before the next rising edge.
    rst_n = 1'b1;
    #2;
    total++;
    if (obs() !== exp) $display("FAIL reset_release_early got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_first_grant();
    tick();
    exp = {1'b1, 4'd0, 16'h0001, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL first_grant got %h want %h", obs(), exp); else passed++;
    tick();
    exp = {1'b1, 4'd0, 16'h0001, 1'b0};
    total++;
    if (obs() !== exp) $display("FAIL first_grant_hold got %h want %h", obs(), exp); else passed++;
    bus.req = 16'h0000;
    tick();
    exp = 22'd0;
    total++;
    if (obs() !== exp) $display("FAIL drop_to_idle got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_rr_wrap();
    logic [3:0]  order [4];
    logic [15:0] oh [4];
    order = '{4'd0, 4'd8, 4'd15, 4'd0};
    oh    = '{16'h0001, 16'h0100, 16'h8000, 16'h0001};
    do_reset();
    bus.req = 16'h8101;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, order[i], oh[i], 1'b1};
      total++;
      if (obs() !== exp) $display("FAIL rr_order[%0d] got %h want %h", i, obs(), exp); else passed++;
      bus.owner_release = 1'b1;
      tick();
      bus.owner_release = 1'b0;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req = 16'h0006;
    tick();
    exp = {1'b1, 4'd1, 16'h0002, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL preempt_first got %h want %h", obs(), exp); else passed++;
    for (int i = 1; i < 4; i++) begin
      tick();
      exp = {1'b1, 4'd1, 16'h0002, 1'b0};
      total++;
      if (obs() !== exp) $display("FAIL preempt_hold[%0d] got %h want %h", i, obs(), exp); else passed++;
    end
    tick();
    exp = {1'b1, 4'd2, 16'h0004, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL preempt_handoff got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_hold_saturate();
    int bad;
    bad = 0;
    do_reset();
    bus.req = 16'h0008;
    tick();
    exp = {1'b1, 4'd3, 16'h0008, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL lone_first got %h want %h", obs(), exp); else passed++;
    exp = {1'b1, 4'd3, 16'h0008, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs() !== exp) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL lone_hold bad_cycles got %0d want 0", bad); else passed++;
    total++;
    if (dbg_hold_cnt !== 8'd10) $display("FAIL lone_hold_cnt got %0d want 10", dbg_hold_cnt); else passed++;
    // Limit already passed: a newcomer preempts at once; search starts at 4, wraps to 0.
    bus.req = 16'h0009;
    tick();
    exp = {1'b1, 4'd0, 16'h0001, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL late_preempt got %h want %h", obs(), exp); else passed++;
    total++;
    if (dbg_hold_cnt !== 8'd0) $display("FAIL late_preempt_cnt got %0d want 0", dbg_hold_cnt); else passed++;
  endtask

  task automatic test_owner_drop();
    do_reset();
    bus.req = 16'h0020;
    tick();
    bus.req = 16'h0200;
    tick();
    exp = {1'b1, 4'd9, 16'h0200, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL owner_drop got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_same_client_regrant();
    do_reset();
    bus.req = 16'h0010;
    tick();
    bus.owner_release = 1'b1;
    tick();
    bus.owner_release = 1'b0;
    exp = {1'b1, 4'd4, 16'h0010, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL regrant_same got %h want %h", obs(), exp); else passed++;
    tick();
    exp = {1'b1, 4'd4, 16'h0010, 1'b0};
    total++;
    if (obs() !== exp) $display("FAIL regrant_pulse_once got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_release_idle();
    do_reset();
    bus.owner_release = 1'b1;
    tick();
    tick();
    bus.owner_release = 1'b0;
    exp = 22'd0;
    total++;
    if (obs() !== exp || dbg_state !== 1'b0)
      $display("FAIL release_idle got %h/%0d want %h/0", obs(), dbg_state, exp);
    else passed++;
  endtask

  task automatic test_release_and_preempt();
    do_reset();
    bus.req = 16'h0006;
    tick();
    tick();
    tick();
    tick();
    bus.owner_release = 1'b1;
    tick();
    bus.owner_release = 1'b0;
    exp = {1'b1, 4'd2, 16'h0004, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL rel_preempt got %h want %h", obs(), exp); else passed++;
    tick();
    exp = {1'b1, 4'd2, 16'h0004, 1'b0};
    total++;
    if (obs() !== exp) $display("FAIL rel_preempt_single got %h want %h", obs(), exp); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 16'h0040;
    tick();
    bus.req = 16'h0080;
    tick();
    exp = {1'b1, 4'd7, 16'h0080, 1'b1};
    total++;
    if (obs() !== exp || dbg_ptr !== 4'd7)
      $display("FAIL async_setup got %h ptr %0d want %h ptr 7", obs(), dbg_ptr, exp);
    else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    exp = 22'd0;
    total++;
    if (obs() !== exp || dbg_ptr !== 4'd0)
      $display("FAIL async_drop got %h ptr %0d want %h ptr 0", obs(), dbg_ptr, exp);
    else passed++;
    tick();
    bus.req = 16'h0081;
    tick();
    rst_n = 1'b1;
    tick();
    exp = {1'b1, 4'd0, 16'h0001, 1'b1};
    total++;
    if (obs() !== exp) $display("FAIL async_restart got %h want %h", obs(), exp); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_first_grant();
    test_rr_wrap();
    test_preempt();
    test_hold_saturate();
    test_owner_drop();
    test_same_client_regrant();
    test_release_idle();
    test_release_and_preempt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter HOLD_LIMIT, default 8, meaning max consecutive grant cycles before forced hand-off; legal range 0..255; 0 disables preemption.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  16  per-client request; bit i = client i.
REQ-005 SHALL have port release  input  1  current owner done; sampled only while grant_valid=1.
REQ-006 SHALL have port grant_valid  output  1  a client currently owns the shared path.
REQ-007 SHALL have port grant_idx  output  4  owner index; drives the 4-bit select of the downstream 16:1 mux.
REQ-008 SHALL have port grant_onehot  output  16  one-hot owner; all zero when grant_valid=0.
REQ-009 SHALL have port grant_new  output  1  one-cycle pulse in the first cycle of each grant.

Function
REQ-010 SHALL register all outputs; no combinational path from req or release to any output.
REQ-011 SHALL implement FSM states IDLE (no owner) and BUSY (owner held).
REQ-012 SHALL keep a 4-bit priority pointer ptr; search order ptr, ptr+1, ..., ptr+15 mod 16; first asserted req bit wins.
REQ-013 IDLE: if req != 0 at edge, SHALL enter BUSY with winner as grant_idx, grant_valid=1, grant_new=1 next cycle (latency 1); else stay IDLE.
REQ-014 BUSY: grant_idx, grant_onehot SHALL remain stable until a hand-off event (REQ-015..017).
REQ-015 Hand-off SHALL occur when release=1, or req[grant_idx]=0 (owner drop treated as release).
REQ-016 Hand-off SHALL occur when HOLD_LIMIT!=0, hold_cnt == HOLD_LIMIT-1, and any other req bit set (preemption).
REQ-017 On hand-off, ptr SHALL become grant_idx+1 mod 16 (15 wraps to 0); arbitration over current req using new ptr; winner granted next cycle with grant_new=1 (back-to-back, no dead cycle); if no req, go IDLE with grant_valid=0.
REQ-018 Releasing client still requesting SHALL be eligible, at lowest priority.
REQ-019 hold_cnt SHALL be 8 bits, clear to 0 on every new grant, increment each BUSY cycle without hand-off, saturate at 255.
REQ-020 If HOLD_LIMIT reached and no other req, owner SHALL keep grant and hold_cnt SHALL saturate; preemption fires on first later cycle another req appears.
REQ-021 release and preemption in same cycle SHALL produce a single hand-off.
REQ-022 release while IDLE SHALL be ignored.
REQ-023 grant_new SHALL be 0 in all cycles except the first cycle of a grant; consecutive grants to the same client via hand-off SHALL each pulse grant_new.
REQ-024 grant_onehot SHALL always equal (grant_valid ? 1<<grant_idx : 0).

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, ptr=0, hold_cnt=0, grant_valid=0, grant_idx=0, grant_onehot=0, grant_new=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant asynchronously; after rst_n rises, first arbitration SHALL start from ptr=0.
REQ-027 Deassertion SHALL be synchronous-safe: first grant no earlier than the edge after rst_n=1 is sampled.

Verification
REQ-028 Reset, req=16'h0001 -> one edge later grant_valid=1, grant_idx=0, grant_onehot=16'h0001, grant_new=1 for one cycle.
REQ-029 ptr=0, req=16'h8101, release pulsed each grant -> grant order 0, 8, 15, 0; 15->0 wrap verified.
REQ-030 HOLD_LIMIT=4, req=16'h0006 held, no release -> client 1 granted 4 cycles, client 2 next cycle with grant_new=1.
REQ-031 HOLD_LIMIT=4, only req[3] for 10 cycles -> grant_idx=3 held all 10 cycles, hold_cnt=10, no grant_new after first.
REQ-032 Owner client 5 drops req[5], req[9]=1, release=0 -> next cycle grant_idx=9, grant_new=1.
REQ-033 rst_n low mid-BUSY (grant_idx=7) -> outputs zero without a clock edge; after release, req=16'h0081 -> grant_idx=0.
